// File: rtl/aes_spi_sequencer.sv
// AES SPI link host sequencer: sends command, text, key length and key
// through the byte-wide SPI master, then reads back one result block.
module aes_spi_sequencer #(
    parameter int BLOCK_BYTES    = 16,
    parameter int MAX_KEY_BYTES  = 32,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       mode,
    input  logic [1:0]                 key_size,
    input  logic [8*BLOCK_BYTES-1:0]   text_in,
    input  logic [8*MAX_KEY_BYTES-1:0] key_in,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [8*BLOCK_BYTES-1:0]   result,
    output logic                       m_start,
    output logic [7:0]                 m_data_in,
    input  logic                       m_busy,
    input  logic                       m_done,
    input  logic [7:0]                 m_data_out,
    input  logic                       s_sending
);
    localparam int TW    = 8 * BLOCK_BYTES;
    localparam int KW    = 8 * MAX_KEY_BYTES;
    localparam int IDX_W = $clog2(BLOCK_BYTES + 2 + MAX_KEY_BYTES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, TX_ISSUE, TX_WAIT, TX_GAP, RX_WAIT_SLAVE,
        RX_ISSUE, RX_WAIT, RX_GAP, FINISH
    } state_t;

    state_t             state;
    logic               mode_q;
    logic               err_q;
    logic [1:0]         ksize_q;
    logic [TW-1:0]      text_q;
    logic [KW-1:0]      key_q;
    logic [TW-1:0]      shift_q;
    logic [IDX_W-1:0]   idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WD_W-1:0]    wd_cnt;

    logic [7:0]         key_len;
    logic [IDX_W-1:0]   last_idx;
    logic [TW-1:0]      text_sh;
    logic [KW-1:0]      key_sh;
    logic [7:0]         tx_byte;
    logic               gap_hit;
    logic               wd_hit;

    // Frame byte at idx: command, text, key length, then key, all MSB first
    always_comb begin
        key_len  = 8'd16 + {3'b000, ksize_q, 3'b000};
        last_idx = IDX_W'(BLOCK_BYTES + 1) + IDX_W'(key_len);
        text_sh  = text_q << {idx - IDX_W'(1), 3'b000};
        key_sh   = key_q << {idx - IDX_W'(BLOCK_BYTES + 2), 3'b000};
        gap_hit  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
        wd_hit   = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
        tx_byte  = 8'h00;
        unique case (1'b1)
            (idx == '0):
                tx_byte = mode_q ? 8'hD0 : 8'hE0;
            (idx != '0 && idx <= IDX_W'(BLOCK_BYTES)):
                tx_byte = text_sh[TW-1 -: 8];
            (idx == IDX_W'(BLOCK_BYTES + 1)):
                tx_byte = key_len;
            default:
                tx_byte = key_sh[KW-1 -: 8];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            ksize_q   <= 2'b00;
            text_q    <= '0;
            key_q     <= '0;
            shift_q   <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            wd_cnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            result    <= '0;
            m_start   <= 1'b0;
            m_data_in <= 8'h00;
        end else begin
            m_start <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            gap_cnt <= '0;
            wd_cnt  <= '0;
            busy    <= (state != IDLE) && (state != FINISH);
            unique case (state)
                IDLE: if (req) begin
                    mode_q  <= mode;
                    ksize_q <= key_size;
                    text_q  <= text_in;
                    key_q   <= key_in;
                    idx     <= '0;
                    err_q   <= (key_size == 2'b11);
                    state   <= (key_size == 2'b11) ? FINISH : TX_ISSUE;
                end
                TX_ISSUE: if (!m_busy) begin
                    m_data_in <= tx_byte;
                    m_start   <= 1'b1;
                    state     <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (m_done) begin
                        if (idx == last_idx) begin
                            idx   <= '0;
                            state <= RX_WAIT_SLAVE;
                        end else begin
                            state <= TX_GAP;
                        end
                    end else if (wd_hit) begin
                        err_q <= 1'b1;
                        state <= FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                TX_GAP: begin
                    if (gap_hit) begin
                        idx   <= idx + IDX_W'(1);
                        state <= TX_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                RX_WAIT_SLAVE: begin
                    if (s_sending) begin
                        state <= RX_ISSUE;
                    end else if (wd_hit) begin
                        err_q <= 1'b1;
                        state <= FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                RX_ISSUE: if (!m_busy) begin
                    m_data_in <= 8'h00;
                    m_start   <= 1'b1;
                    state     <= RX_WAIT;
                end
                RX_WAIT: begin
                    if (m_done) begin
                        shift_q <= {shift_q[TW-9:0], m_data_out};
                        state   <= (idx == IDX_W'(BLOCK_BYTES - 1))
                                   ? FINISH : RX_GAP;
                    end else if (wd_hit) begin
                        err_q <= 1'b1;
                        state <= FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                RX_GAP: begin
                    if (gap_hit) begin
                        idx   <= idx + IDX_W'(1);
                        state <= RX_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    error <= err_q;
                    if (!err_q) result <= shift_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Bench for aes_spi_sequencer: SPI master and AES slave stubs plus a
// frame/result reference built from the transaction rules.
module tb_aes_spi_sequencer;
    localparam int GAP = 4;
    localparam int TMO = 100;

    logic         clk;
    logic         reset;
    logic         req;
    logic         mode;
    logic [1:0]   key_size;
    logic [127:0] text_in;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         error;
    logic [127:0] result;
    logic         m_start;
    logic [7:0]   m_data_in;
    logic         m_busy;
    logic         m_done;
    logic [7:0]   m_data_out;
    logic         s_sending;

    aes_spi_sequencer #(
        .BLOCK_BYTES(16),
        .MAX_KEY_BYTES(32),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .mode(mode),
        .key_size(key_size),
        .text_in(text_in),
        .key_in(key_in),
        .busy(busy),
        .done(done),
        .error(error),
        .result(result),
        .m_start(m_start),
        .m_data_in(m_data_in),
        .m_busy(m_busy),
        .m_done(m_done),
        .m_data_out(m_data_out),
        .s_sending(s_sending)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int instab = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_in_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] exp_q[$];
    int starts[$];
    int dones[$];
    logic [127:0] exp_result = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master + slave stub; dones[] holds the edge that samples m_done
    initial begin : master_model
        logic [7:0] b;
        int n;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                b = m_data_in;
                starts.push_back(cyc);
                if (s_sending) rx_in_q.push_back(b);
                else tx_q.push_back(b);
                m_busy = 1'b1;
                n = $urandom_range(1, 5);
                repeat (n) @(negedge clk);
                if (m_data_in !== b) instab++;
                m_done = 1'b1;
                if (s_sending && resp_q.size() > 0)
                    m_data_out = resp_q.pop_front();
                else
                    m_data_out = 8'($urandom);
                dones.push_back(cyc + 1);
                @(negedge clk);
                m_done = 1'b0;
                m_busy = 1'b0;
                m_data_out = 8'($urandom);
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build_frame(input logic m, input logic [1:0] ks,
                                        input logic [127:0] txt,
                                        input logic [255:0] key);
        int klen;
        klen = 16 + 8 * int'(ks);
        exp_q.delete();
        exp_q.push_back(m ? 8'hD0 : 8'hE0);
        for (int i = 0; i < 16; i++) exp_q.push_back(txt[127-8*i -: 8]);
        exp_q.push_back(8'(klen));
        for (int i = 0; i < klen; i++) exp_q.push_back(key[255-8*i -: 8]);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_logs();
        tx_q.delete();
        rx_in_q.delete();
        resp_q.delete();
        starts.delete();
        dones.delete();
    endtask

    task automatic run_request(input string tag, input logic m,
                               input logic [1:0] ks,
                               input logic [127:0] txt,
                               input logic [255:0] key,
                               input logic [127:0] resp,
                               input bit slave_ok, input bit poke);
        int flen, dcyc, bad, tmo_exp;
        build_frame(m, ks, txt, key);
        flen = exp_q.size();
        clear_logs();
        for (int i = 0; i < 16; i++) resp_q.push_back(resp[127-8*i -: 8]);
        @(negedge clk);
        mode = m; key_size = ks; text_in = txt; key_in = key; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk({tag, "_busy_accept"}, busy, 0);
        @(negedge clk);
        chk({tag, "_busy_n1"}, busy, 1);
        chk({tag, "_mstart_n1"}, m_start, 1);
        for (int k = 0; k < 4000 && dones.size() < flen; k++) begin
            @(negedge clk);
            req = poke && tx_q.size() >= 5 && tx_q.size() <= 7;
            mode = ~m;
        end
        req = 1'b0;
        chk({tag, "_tx_count"}, tx_q.size(), flen);
        bad = 0;
        for (int i = 0; i < flen && i < tx_q.size(); i++)
            if (tx_q[i] !== exp_q[i]) bad++;
        chk({tag, "_tx_bytes_bad"}, bad, 0);
        chk({tag, "_cmd"}, tx_q.size() > 0 ? tx_q[0] : 8'hxx,
            m ? 8'hD0 : 8'hE0);
        if (slave_ok) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            s_sending = 1'b1;
        end
        dcyc = -1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        chk({tag, "_done_seen"}, dcyc >= 0, 1);
        chk({tag, "_error"}, error, !slave_ok);
        chk({tag, "_busy_at_done"}, busy, 0);
        if (slave_ok) begin
            chk({tag, "_result"}, result, resp);
            exp_result = resp;
            chk({tag, "_rx_count"}, rx_in_q.size(), 16);
            bad = 0;
            foreach (rx_in_q[i]) if (rx_in_q[i] !== 8'h00) bad++;
            chk({tag, "_rx_fill_bad"}, bad, 0);
            bad = 0;
            for (int i = 1; i < starts.size() && i < dones.size() + 1; i++)
                if (i != flen && starts[i] != dones[i-1] + 1 + GAP) bad++;
            chk({tag, "_spacing_bad"}, bad, 0);
        end else begin
            tmo_exp = (dones.size() >= flen) ? dones[flen-1] + TMO + 1 : -1;
            chk({tag, "_timeout_cycle"}, dcyc, tmo_exp);
            chk({tag, "_result_kept"}, result, exp_result);
            chk({tag, "_no_rx"}, rx_in_q.size(), 0);
        end
        s_sending = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_instab"}, instab, 0);
    endtask

    initial begin : stim
        logic [255:0] k;
        int hit, nd;
        reset = 1'b0; req = 1'b0; mode = 1'b0; key_size = 2'b00;
        text_in = '0; key_in = '0; s_sending = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_mdata", m_data_in, 0);
        chk("rst_result", result, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        k = {128'h000102030405060708090a0b0c0d0e0f, rnd128()};
        run_request("aes128", 1'b0, 2'b00,
                    128'h00112233445566778899aabbccddeeff, k,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 1);

        clear_logs();
        @(negedge clk);
        key_size = 2'b11; mode = 1'b0; text_in = rnd128(); req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("inv_busy_accept", busy, 0);
        @(negedge clk);
        chk("inv_done", done, 1);
        chk("inv_error", error, 1);
        chk("inv_busy", busy, 0);
        chk("inv_result_kept", result, exp_result);
        repeat (10) @(negedge clk);
        chk("inv_no_mstart", starts.size(), 0);
        chk("inv_done_low", done, 0);

        k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
             $urandom(), $urandom()};
        run_request("aes192", 1'b0, 2'b01,
                    128'h00112233445566778899aabbccddeeff, k,
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1, 0);
        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run_request("aes256", 1'b0, 2'b10,
                    128'h00112233445566778899aabbccddeeff, k,
                    128'h8ea2b7ca516745bfeafc49904b496089, 1, 0);
        k = {128'h000102030405060708090a0b0c0d0e0f, rnd128()};
        run_request("dec128", 1'b1, 2'b00,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, k,
                    128'h00112233445566778899aabbccddeeff, 1, 0);

        run_request("timeout", 1'b0, 2'b00, rnd128(), {rnd128(), rnd128()},
                    rnd128(), 0, 0);
        run_request("after_tmo", 1'b1, 2'b01, rnd128(), {rnd128(), rnd128()},
                    rnd128(), 1, 0);

        for (int i = 0; i < 4; i++)
            run_request("rand", 1'($urandom), 2'($urandom_range(0, 2)),
                        rnd128(), {rnd128(), rnd128()}, rnd128(), 1, 1);

        clear_logs();
        @(negedge clk);
        mode = 1'b0; key_size = 2'b10; text_in = rnd128();
        key_in = {rnd128(), rnd128()}; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int j = 0; j < 3000 && tx_q.size() < 19; j++) @(negedge clk);
        hit = 0;
        for (int j = 0; j < 200; j++) begin
            @(posedge clk);
            #1;
            if (m_start === 1'b1) begin
                hit = 1;
                break;
            end
        end
        chk("mid_byte20", hit, 1);
        reset = 1'b0;
        #1;
        chk("mid_mstart", m_start, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        chk("mid_mdata", m_data_in, 0);
        chk("mid_result", result, 0);
        exp_result = '0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0) nd++;
        end
        chk("mid_no_done", nd, 0);
        reset = 1'b1;
        @(negedge clk);
        run_request("post_rst", 1'b0, 2'b10, rnd128(), {rnd128(), rnd128()},
                    rnd128(), 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
